// File: rtl/first_nios2_system_sysid_arbiter.sv
// Round-robin read arbiter between the CPU and JTAG masters for the sysid control slave.
// Optional response cache enabled by defining SYSID_ARB_CACHE_EN.
module first_nios2_system_sysid_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              sysid_address,
    input  logic [DATA_W-1:0] sysid_readdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              grant, grant_next;
    logic              addr, addr_next;
    logic              last_grant, last_grant_next;
    logic              req_any;
    logic              win;
    logic              win_addr;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              accept0;
    logic              accept1;

    // Arbitration: on a tie the master other than the last one granted wins.
    always_comb begin
        req_any  = m0_read | m1_read;
        win      = (m0_read & m1_read) ? ~last_grant : m1_read;
        win_addr = win ? m1_address : m0_address;
    end

`ifdef SYSID_ARB_CACHE_EN
    logic [DATA_W-1:0] cache_data [2];
    logic [1:0]        cache_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            cache_valid <= 2'b00;
        end else if (state == ACCESS) begin
            cache_valid[addr] <= 1'b1;
        end
    end

    // Data needs no reset; the valid bits qualify it.
    always_ff @(posedge clock) begin
        if (state == ACCESS) begin
            cache_data[addr] <= sysid_readdata;
        end
    end

    assign hit      = cache_valid[win_addr];
    assign hit_data = cache_data[win_addr];
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        addr_next       = addr;
        last_grant_next = last_grant;
        load            = 1'b0;
        load_data       = sysid_readdata;
        accept0         = 1'b0;
        accept1         = 1'b0;
        sysid_address   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    grant_next      = win;
                    addr_next       = win_addr;
                    last_grant_next = win;
                    if (hit) begin
                        state_next = RESP;
                        load       = 1'b1;
                        load_data  = hit_data;
                        accept0    = ~win;
                        accept1    = win;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                sysid_address = addr;
                load          = 1'b1;
                accept0       = ~grant;
                accept1       = grant;
                state_next    = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // While reset is held nothing is accepted, so waitrequest mirrors read.
    assign m0_waitrequest = m0_read & ~(accept0 & ~reset);
    assign m1_waitrequest = m1_read & ~(accept1 & ~reset);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            grant            <= 1'b0;
            addr             <= 1'b0;
            last_grant       <= 1'b1;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            state            <= state_next;
            grant            <= grant_next;
            addr             <= addr_next;
            last_grant       <= last_grant_next;
            m0_readdatavalid <= load & ~grant_next;
            m1_readdatavalid <= load & grant_next;
            if (load & ~grant_next) begin
                m0_readdata <= load_data;
            end
            if (load & grant_next) begin
                m1_readdata <= load_data;
            end
        end
    end

endmodule
